// File: rtl/efuse_ctrl_arb_pkg.sv
// efuse_pkg: shared types and constants for the eFuse sequencer/arbiter.
//   ctrl_state_e  : FSM state encoding (plain logic constants so the encoding
//                   stays stable for legacy tools and waveform decoders)
//   EFUSE_NW/WSEL : default word width / word count of the 256-bit array
//   ERR_*         : bit positions inside err_o
package efuse_pkg;

   localparam int EFUSE_NW   = 64;
   localparam int EFUSE_WSEL = 256 / EFUSE_NW;
   localparam int EFUSE_TOW  = 16;

   typedef logic [2:0] ctrl_state_e;

   localparam ctrl_state_e ST_BOOT      = 3'd0;
   localparam ctrl_state_e ST_BOOT_WAIT = 3'd1;
   localparam ctrl_state_e ST_IDLE      = 3'd2;
   localparam ctrl_state_e ST_WR        = 3'd3;
   localparam ctrl_state_e ST_VFY       = 3'd4;
   localparam ctrl_state_e ST_RD        = 3'd5;
   localparam ctrl_state_e ST_ERR       = 3'd6;

   localparam int ERR_LOCK = 0;
   localparam int ERR_VFY  = 1;
   localparam int ERR_TO   = 2;

endpackage

// File: rtl/efuse_ctrl_arb_if.sv
// efuse_ctrl_arb_if: handshake + pin bundle between the controller and the
// efuse_write / efuse_read engines.
//   master : controller side (drives start/sel/data, receives done/data/pins)
//   slave  : engine side
interface efuse_ctrl_arb_if #(
   parameter int NW = 64,
   parameter int SW = 2
);
   // to / from efuse_write
   logic          wr_start_o;
   logic [SW-1:0] wr_sel_o;
   logic [NW-1:0] wr_data_o;
   logic          wr_done_i;
   logic          wr_pgmen_i;
   logic          wr_rden_i;
   logic          wr_aen_i;
   logic [7:0]    wr_addr_i;
   // to / from efuse_read
   logic          rd_start_o;
   logic [SW-1:0] rd_sel_o;
   logic          rd_done_i;
   logic [NW-1:0] rd_data_i;
   logic          rd_rden_i;
   logic          rd_aen_i;
   logic [7:0]    rd_addr_i;

   modport master (
      output wr_start_o, wr_sel_o, wr_data_o, rd_start_o, rd_sel_o,
      input  wr_done_i, wr_pgmen_i, wr_rden_i, wr_aen_i, wr_addr_i,
      input  rd_done_i, rd_data_i, rd_rden_i, rd_aen_i, rd_addr_i
   );

   modport slave (
      input  wr_start_o, wr_sel_o, wr_data_o, rd_start_o, rd_sel_o,
      output wr_done_i, wr_pgmen_i, wr_rden_i, wr_aen_i, wr_addr_i,
      output rd_done_i, rd_data_i, rd_rden_i, rd_aen_i, rd_addr_i
   );
endinterface

// File: rtl/efuse_ctrl_arb_pin_mux.sv
// efuse_pin_mux: selects which engine owns the eFuse macro pins.
//   state        : registered controller state
//   wr_* / rd_*  : pins requested by efuse_write / efuse_read
//   pgmen/rden/aen/addr : pins to the macro
// WR hands the macro to the writer; boot, verify and read hand it to the
// reader (which has no pgmen, so pgmen is 0 there). Everything else parks
// the macro with all pins low.
module efuse_pin_mux
   import efuse_pkg::*;
(
   input  ctrl_state_e state,
   input  logic        wr_pgmen,
   input  logic        wr_rden,
   input  logic        wr_aen,
   input  logic [7:0]  wr_addr,
   input  logic        rd_rden,
   input  logic        rd_aen,
   input  logic [7:0]  rd_addr,
   output logic        pgmen,
   output logic        rden,
   output logic        aen,
   output logic [7:0]  addr
);

   always_comb begin
      pgmen = 1'b0;
      rden  = 1'b0;
      aen   = 1'b0;
      addr  = 8'h00;
      case (state)
         ST_WR: begin
            pgmen = wr_pgmen;
            rden  = wr_rden;
            aen   = wr_aen;
            addr  = wr_addr;
         end
         ST_BOOT, ST_BOOT_WAIT, ST_VFY, ST_RD: begin
            rden = rd_rden;
            aen  = rd_aen;
            addr = rd_addr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/efuse_ctrl_arb.sv
// efuse_ctrl_arb: eFuse sequencer / arbiter.
//   clk, rst            : clock, async active-high reset
//   sw_wr_req/sel/data  : SW program request (1-cycle pulse)
//   sw_rd_req/sel       : SW re-read request (1-cycle pulse)
//   pgm_unlock          : programming key, 0 rejects writes
//   rg_timeout          : per-transaction watchdog limit (0 = off)
//   eng                 : engine handshake bundle (master side)
//   efuse_*_o           : muxed macro pins
//   shadow_o            : shadow copy, word k at [k*NW +: NW]
//   load_done/busy/err_o: status; err_o = {timeout, verify_fail, lock_reject}
// After reset every word is auto-loaded into the shadow. Afterwards a
// pending write (always followed by a read-back verify) beats a pending read.
module efuse_ctrl_arb
   import efuse_pkg::*;
#(
   parameter int  NW   = EFUSE_NW,
   parameter int  WSEL = 256 / NW,
   parameter int  TOW  = EFUSE_TOW,
   localparam int SW   = (WSEL > 1) ? $clog2(WSEL) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sw_wr_req,
   input  logic [SW-1:0]      sw_wr_sel,
   input  logic [NW-1:0]      sw_wr_data,
   input  logic               sw_rd_req,
   input  logic [SW-1:0]      sw_rd_sel,
   input  logic               pgm_unlock,
   input  logic [TOW-1:0]     rg_timeout,
   efuse_ctrl_arb_if.master   eng,
   output logic               efuse_pgmen_o,
   output logic               efuse_rden_o,
   output logic               efuse_aen_o,
   output logic [7:0]         efuse_addr_o,
   output logic [NW*WSEL-1:0] shadow_o,
   output logic               load_done,
   output logic               busy,
   output logic [2:0]         err_o
);

   ctrl_state_e   state, state_n;
   logic [SW-1:0] cnt;
   logic [TOW-1:0] wd_cnt;
   logic [TOW:0]  wd_inc;
   logic          wd_exp, waiting;

   logic          wr_pend, rd_pend;
   logic [SW-1:0] wr_pend_sel, rd_pend_sel;
   logic [NW-1:0] wr_pend_data;

   logic          wr_start_q, rd_start_q;
   logic [SW-1:0] wr_sel_q, rd_sel_q, rd_sel_n;
   logic [NW-1:0] wr_data_q;

   logic start_wr, start_rd, store_rd, take_wr, take_rd, lock_rej;
   logic boot_next, boot_fin, vfy_fail;

   assign eng.wr_start_o = wr_start_q;
   assign eng.wr_sel_o   = wr_sel_q;
   assign eng.wr_data_o  = wr_data_q;
   assign eng.rd_start_o = rd_start_q;
   assign eng.rd_sel_o   = rd_sel_q;

   // Watchdog counts cycles spent waiting for a done; a done arriving on the
   // expiry cycle is checked first in the FSM and therefore wins.
   assign waiting = (state == ST_BOOT_WAIT) || (state == ST_WR) ||
                    (state == ST_VFY) || (state == ST_RD);
   assign wd_inc  = {1'b0, wd_cnt} + 1'b1;
   assign wd_exp  = (rg_timeout != '0) && (wd_inc >= {1'b0, rg_timeout});

   // Only bits that were asked to blow are checked; extra 1s already in the
   // fuse are not a failure.
   assign vfy_fail = (state == ST_VFY) && eng.rd_done_i &&
                     ((eng.rd_data_i & wr_data_q) != wr_data_q);

   always_comb begin
      state_n   = state;
      start_wr  = 1'b0;
      start_rd  = 1'b0;
      rd_sel_n  = rd_sel_q;
      store_rd  = 1'b0;
      take_wr   = 1'b0;
      take_rd   = 1'b0;
      lock_rej  = 1'b0;
      boot_next = 1'b0;
      boot_fin  = 1'b0;
      case (state)
         ST_BOOT: begin
            state_n  = ST_BOOT_WAIT;
            start_rd = 1'b1;
            rd_sel_n = cnt;
         end
         ST_BOOT_WAIT: begin
            if (eng.rd_done_i) begin
               store_rd = 1'b1;
               if (cnt == SW'(WSEL - 1)) begin
                  state_n  = ST_IDLE;
                  boot_fin = 1'b1;
               end else begin
                  state_n   = ST_BOOT;
                  boot_next = 1'b1;
               end
            end else if (wd_exp) begin
               state_n = ST_ERR;
            end
         end
         ST_IDLE: begin
            if (wr_pend) begin
               take_wr = 1'b1;
               if (pgm_unlock) begin
                  state_n  = ST_WR;
                  start_wr = 1'b1;
               end else begin
                  lock_rej = 1'b1;
               end
            end else if (rd_pend) begin
               take_rd  = 1'b1;
               state_n  = ST_RD;
               start_rd = 1'b1;
               rd_sel_n = rd_pend_sel;
            end
         end
         ST_WR: begin
            if (eng.wr_done_i) begin
               state_n  = ST_VFY;
               start_rd = 1'b1;
               rd_sel_n = wr_sel_q;
            end else if (wd_exp) begin
               state_n = ST_ERR;
            end
         end
         ST_VFY, ST_RD: begin
            if (eng.rd_done_i) begin
               store_rd = 1'b1;
               state_n  = ST_IDLE;
            end else if (wd_exp) begin
               state_n = ST_ERR;
            end
         end
         default: state_n = ST_ERR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_BOOT;
         cnt          <= '0;
         wd_cnt       <= '0;
         wr_pend      <= 1'b0;
         rd_pend      <= 1'b0;
         wr_pend_sel  <= '0;
         rd_pend_sel  <= '0;
         wr_pend_data <= '0;
         wr_start_q   <= 1'b0;
         rd_start_q   <= 1'b0;
         wr_sel_q     <= '0;
         rd_sel_q     <= '0;
         wr_data_q    <= '0;
         shadow_o     <= '0;
         load_done    <= 1'b0;
         busy         <= 1'b0;
         err_o        <= 3'b000;
      end else begin
         state      <= state_n;
         busy       <= (state_n != ST_IDLE) && (state_n != ST_ERR);
         wr_start_q <= start_wr;
         rd_start_q <= start_rd;
         rd_sel_q   <= rd_sel_n;

         if (start_wr) begin
            wr_sel_q  <= wr_pend_sel;
            wr_data_q <= wr_pend_data;
         end

         if (start_wr || start_rd) wd_cnt <= '0;
         else if (waiting)         wd_cnt <= wd_inc[TOW-1:0];

         if (boot_next) cnt       <= cnt + 1'b1;
         if (boot_fin)  load_done <= 1'b1;

         if (store_rd) shadow_o[rd_sel_q*NW +: NW] <= eng.rd_data_i;

         // Clear on service first so a request landing the same cycle stays pending.
         if (take_wr) wr_pend <= 1'b0;
         if (take_rd) rd_pend <= 1'b0;
         if (sw_wr_req) begin
            wr_pend      <= 1'b1;
            wr_pend_sel  <= sw_wr_sel;
            wr_pend_data <= sw_wr_data;
         end
         if (sw_rd_req) begin
            rd_pend     <= 1'b1;
            rd_pend_sel <= sw_rd_sel;
         end

         if (lock_rej) err_o[ERR_LOCK] <= 1'b1;
         if (vfy_fail) err_o[ERR_VFY]  <= 1'b1;
         if ((state_n == ST_ERR) && (state != ST_ERR)) err_o[ERR_TO] <= 1'b1;
      end
   end

   efuse_pin_mux u_pin_mux (
      .state    (state),
      .wr_pgmen (eng.wr_pgmen_i),
      .wr_rden  (eng.wr_rden_i),
      .wr_aen   (eng.wr_aen_i),
      .wr_addr  (eng.wr_addr_i),
      .rd_rden  (eng.rd_rden_i),
      .rd_aen   (eng.rd_aen_i),
      .rd_addr  (eng.rd_addr_i),
      .pgmen    (efuse_pgmen_o),
      .rden     (efuse_rden_o),
      .aen      (efuse_aen_o),
      .addr     (efuse_addr_o)
   );

endmodule

// File: tb/tb_efuse_ctrl_arb.sv
// tb_efuse_ctrl_arb: behavioural efuse_write / efuse_read models around the
// arbiter, a start-event scoreboard and directed status/shadow checks.
module tb_efuse_ctrl_arb;
   import efuse_pkg::*;

   localparam int NW = 64, WSEL = 4, TOW = 16, SW = 2, TPGM = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic           sw_wr_req = 1'b0;
   logic [SW-1:0]  sw_wr_sel = '0;
   logic [NW-1:0]  sw_wr_data = '0;
   logic           sw_rd_req = 1'b0;
   logic [SW-1:0]  sw_rd_sel = '0;
   logic           pgm_unlock = 1'b0;
   logic [TOW-1:0] rg_timeout = '0;
   logic           efuse_pgmen_o, efuse_rden_o, efuse_aen_o;
   logic [7:0]     efuse_addr_o;
   logic [NW*WSEL-1:0] shadow_o;
   logic           load_done, busy;
   logic [2:0]     err_o;

   efuse_ctrl_arb_if #(.NW(NW), .SW(SW)) eng_if ();

   efuse_ctrl_arb #(.NW(NW), .WSEL(WSEL), .TOW(TOW)) dut (
      .clk(clk), .rst(rst),
      .sw_wr_req(sw_wr_req), .sw_wr_sel(sw_wr_sel), .sw_wr_data(sw_wr_data),
      .sw_rd_req(sw_rd_req), .sw_rd_sel(sw_rd_sel),
      .pgm_unlock(pgm_unlock), .rg_timeout(rg_timeout),
      .eng(eng_if),
      .efuse_pgmen_o(efuse_pgmen_o), .efuse_rden_o(efuse_rden_o),
      .efuse_aen_o(efuse_aen_o), .efuse_addr_o(efuse_addr_o),
      .shadow_o(shadow_o), .load_done(load_done), .busy(busy), .err_o(err_o)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // ---------------- fuse array + engine models ----------------
   logic [NW-1:0] fuse [WSEL] = '{64'hf1, 64'h13, 64'h34, 64'h56};
   logic          rd_ovr_en = 1'b0;
   logic [NW-1:0] rd_ovr_val = 64'h10;
   logic          rd_suppress = 1'b0;

   // Models reset synchronously so an async DUT reset cannot hide behind them.
   int            wr_cnt;
   logic          wr_act = 1'b0;
   logic [SW-1:0] wm_sel;
   logic [NW-1:0] wm_data;
   always @(posedge clk) begin
      eng_if.wr_rden_i <= 1'b0;
      if (rst) begin
         wr_act <= 1'b0;
         eng_if.wr_done_i  <= 1'b0;
         eng_if.wr_pgmen_i <= 1'b0;
         eng_if.wr_aen_i   <= 1'b0;
         eng_if.wr_addr_i  <= 8'h00;
      end else begin
         eng_if.wr_done_i <= 1'b0;
         if (eng_if.wr_start_o) begin
            wr_act  <= 1'b1;
            wr_cnt  <= 0;
            wm_sel  <= eng_if.wr_sel_o;
            wm_data <= eng_if.wr_data_o;
            eng_if.wr_pgmen_i <= 1'b1;
            eng_if.wr_aen_i   <= 1'b1;
            eng_if.wr_addr_i  <= {6'd0, eng_if.wr_sel_o};
         end else if (wr_act) begin
            if (wr_cnt == TPGM - 1) begin
               wr_act <= 1'b0;
               eng_if.wr_pgmen_i <= 1'b0;
               eng_if.wr_aen_i   <= 1'b0;
               eng_if.wr_done_i  <= 1'b1;
               fuse[wm_sel]      <= fuse[wm_sel] | wm_data;
            end else begin
               wr_cnt <= wr_cnt + 1;
            end
         end
      end
   end

   int            rm_cnt;
   logic          rd_act = 1'b0;
   logic [SW-1:0] rm_sel;
   always @(posedge clk) begin
      if (rst) begin
         rd_act <= 1'b0;
         eng_if.rd_done_i <= 1'b0;
         eng_if.rd_data_i <= '0;
         eng_if.rd_rden_i <= 1'b0;
         eng_if.rd_aen_i  <= 1'b0;
         eng_if.rd_addr_i <= 8'h00;
      end else begin
         eng_if.rd_done_i <= 1'b0;
         if (eng_if.rd_start_o) begin
            rd_act <= 1'b1;
            rm_cnt <= 0;
            rm_sel <= eng_if.rd_sel_o;
            eng_if.rd_rden_i <= 1'b1;
            eng_if.rd_aen_i  <= 1'b1;
            eng_if.rd_addr_i <= {6'd0, eng_if.rd_sel_o};
         end else if (rd_act) begin
            if (rm_cnt == 2 && !rd_suppress) begin
               rd_act <= 1'b0;
               eng_if.rd_rden_i <= 1'b0;
               eng_if.rd_aen_i  <= 1'b0;
               eng_if.rd_done_i <= 1'b1;
               eng_if.rd_data_i <= rd_ovr_en ? rd_ovr_val : fuse[rm_sel];
            end else if (rm_cnt < 2) begin
               rm_cnt <= rm_cnt + 1;
            end
         end
      end
   end

   // ---------------- scoreboard of start pulses ----------------
   typedef struct {
      bit            is_wr;
      logic [SW-1:0] sel;
      logic [NW-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   task automatic push_exp(input bit is_wr, input logic [SW-1:0] sel, input logic [NW-1:0] data);
      exp_t e;
      e.is_wr = is_wr; e.sel = sel; e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic sb_pop(input bit is_wr, input logic [SW-1:0] sel, input logic [NW-1:0] data);
      exp_t e;
      check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check_val("sb_kind", 64'(is_wr), 64'(e.is_wr));
         check_val("sb_sel", 64'(sel), 64'(e.sel));
         if (is_wr) check_val("sb_data", data, e.data);
      end
   endtask

   int   cyc = 0;
   int   last_rd_cyc = 0;
   logic pg_in_rd = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rd_act && efuse_pgmen_o) pg_in_rd <= 1'b1;
      if (eng_if.wr_start_o) sb_pop(1'b1, eng_if.wr_sel_o, eng_if.wr_data_o);
      if (eng_if.rd_start_o) begin
         last_rd_cyc <= cyc;
         sb_pop(1'b0, eng_if.rd_sel_o, '0);
      end
   end

   // ---------------- helpers ----------------
   task automatic pulse_req(input bit wr, input bit rd, input logic [SW-1:0] wsel,
                            input logic [NW-1:0] wdata, input logic [SW-1:0] rsel);
      sw_wr_req = wr; sw_wr_sel = wsel; sw_wr_data = wdata;
      sw_rd_req = rd; sw_rd_sel = rsel;
      @(negedge clk);
      sw_wr_req = 1'b0;
      sw_rd_req = 1'b0;
   endtask

   task automatic push_boot();
      for (int k = 0; k < WSEL; k++) push_exp(1'b0, SW'(k), '0);
   endtask

   task automatic wait_load();
      int n = 0;
      while (!load_done && n < 300) begin @(negedge clk); n++; end
      check_val("load_done", 64'(load_done), 64'd1);
   endtask

   task automatic wait_idle();
      int run = 0;
      int n = 0;
      while (run < 4 && n < 500) begin
         @(negedge clk); n++;
         if (!busy && !wr_act && !rd_act) run++; else run = 0;
      end
      check_val("idle_reached", 64'(run >= 4), 64'd1);
   endtask

   function automatic logic [NW-1:0] sh(input int k);
      return shadow_o[k*NW +: NW];
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int n;
      logic busy_seen;

      // reset state + autoload
      repeat (10) @(negedge clk);
      check_val("rst_err", 64'(err_o), 64'd0);
      check_val("rst_load_done", 64'(load_done), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_shadow", sh(0) | sh(3), 64'd0);
      check_val("rst_pins", 64'({efuse_pgmen_o, efuse_rden_o, efuse_aen_o}), 64'd0);
      push_boot();
      rst = 1'b0;
      wait_load();
      check_val("boot_sh0", sh(0), 64'hf1);
      check_val("boot_sh1", sh(1), 64'h13);
      check_val("boot_sh2", sh(2), 64'h34);
      check_val("boot_sh3", sh(3), 64'h56);
      wait_idle();
      check_val("boot_drained", 64'(exp_q.size()), 64'd0);

      // unlocked write with verify
      pgm_unlock = 1'b1;
      push_exp(1'b1, 2'd0, 64'hf1);
      push_exp(1'b0, 2'd0, '0);
      pulse_req(1'b1, 1'b0, 2'd0, 64'hf1, 2'd0);
      wait_idle();
      check_val("wr_err", 64'(err_o), 64'd0);
      check_val("wr_sh0", sh(0), 64'hf1);
      check_val("wr_drained", 64'(exp_q.size()), 64'd0);

      // locked write is rejected, never goes busy
      pgm_unlock = 1'b0;
      busy_seen = 1'b0;
      pulse_req(1'b1, 1'b0, 2'd1, 64'hff, 2'd0);
      repeat (10) begin @(negedge clk); busy_seen |= busy; end
      check_val("lock_err", 64'(err_o), 64'b001);
      check_val("lock_busy", 64'(busy_seen), 64'd0);
      check_val("lock_sh1", sh(1), 64'h13);

      // simultaneous write + read: write and verify first, then the read
      pgm_unlock = 1'b1;
      push_exp(1'b1, 2'd2, 64'h34);
      push_exp(1'b0, 2'd2, '0);
      push_exp(1'b0, 2'd3, '0);
      pulse_req(1'b1, 1'b1, 2'd2, 64'h34, 2'd3);
      wait_idle();
      check_val("arb_err", 64'(err_o), 64'b001);
      check_val("arb_sh2", sh(2), 64'h34);
      check_val("arb_sh3", sh(3), 64'h56);
      check_val("arb_drained", 64'(exp_q.size()), 64'd0);

      // verify failure: reader returns 0x10 after 0x34 was programmed
      rd_ovr_en = 1'b1;
      push_exp(1'b1, 2'd2, 64'h34);
      push_exp(1'b0, 2'd2, '0);
      pulse_req(1'b1, 1'b0, 2'd2, 64'h34, 2'd0);
      wait_idle();
      rd_ovr_en = 1'b0;
      check_val("vfy_err", 64'(err_o), 64'b011);
      check_val("vfy_sh2", sh(2), 64'h10);

      // watchdog: done suppressed, 20-cycle limit
      rg_timeout = 16'd20;
      rd_suppress = 1'b1;
      push_exp(1'b0, 2'd1, '0);
      pulse_req(1'b0, 1'b1, 2'd0, '0, 2'd1);
      n = 0;
      while (!err_o[2] && n < 100) begin @(negedge clk); n++; end
      check_val("to_err", 64'(err_o), 64'b111);
      check_val("to_lat", 64'(cyc - last_rd_cyc), 64'd20);
      check_val("to_busy", 64'(busy), 64'd0);
      check_val("to_pins", 64'({efuse_rden_o, efuse_aen_o}), 64'd0);
      // ERR is terminal: a new request must not start anything
      pulse_req(1'b0, 1'b1, 2'd0, '0, 2'd0);
      repeat (10) @(negedge clk);
      check_val("err_sticky", 64'(err_o), 64'b111);

      // reset clears ERR and reloads
      exp_q.delete();
      rst = 1'b1;
      rd_suppress = 1'b0;
      rg_timeout = '0;
      repeat (3) @(negedge clk);
      push_boot();
      rst = 1'b0;
      wait_load();
      check_val("rl_err", 64'(err_o), 64'd0);
      check_val("rl_sh2", sh(2), 64'h34);
      wait_idle();

      // reset in the middle of programming
      push_exp(1'b1, 2'd3, 64'h57);
      pulse_req(1'b1, 1'b0, 2'd3, 64'h57, 2'd0);
      n = 0;
      while (!efuse_pgmen_o && n < 50) begin @(negedge clk); n++; end
      check_val("mid_pgmen", 64'(efuse_pgmen_o), 64'd1);
      @(negedge clk);
      exp_q.delete();
      push_boot();
      rst = 1'b1;
      #1;
      check_val("mid_rst_pgmen", 64'(efuse_pgmen_o), 64'd0);
      check_val("mid_rst_busy", 64'(busy), 64'd0);
      check_val("mid_rst_load", 64'(load_done), 64'd0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      wait_load();
      check_val("rb_sh0", sh(0), 64'hf1);
      check_val("rb_sh3", sh(3), 64'h56);
      wait_idle();
      check_val("rb_drained", 64'(exp_q.size()), 64'd0);
      check_val("pgmen_in_rd", 64'(pg_in_rd), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
